// File: rtl/i2c_target_regs.sv
// I2C target with a small register bank, clocked entirely by pclk.
// SCL/SDA are oversampled; SDA is driven open-drain through sda_oe, and SCL
// is never driven.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] REG_RST     = 8'h00,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          pclk,
    input  logic          preset_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, RD_WAIT
    } state_t;

    logic          scl_s1_reg, scl_s2_reg, scl_hist_reg;
    logic          sda_s1_reg, sda_s2_reg, sda_hist_reg;
    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    // Only 7 bits are kept: on receive the 8th bit comes straight from the
    // pin, and on transmit bit 7 is driven the moment the byte is loaded.
    logic [6:0]    shreg_reg, shreg_next;
    logic          rw_reg, rw_next;
    logic          first_byte_reg, first_byte_next;
    logic          ack_phase_reg, ack_phase_next;
    logic          sda_oe_reg, sda_oe_next;
    logic          busy_reg, busy_next;
    logic [AW-1:0] pointer_reg, pointer_next;
    logic          wr_stb_reg, wr_stb_next;
    logic [AW-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]    wr_data_reg, wr_data_next;
    logic [7:0]    regs [NUM_REGS];

    logic scl_rise, scl_fall, sda_rise, sda_fall, scl_high, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;

    // Edge and bus-condition decode; an SDA edge coinciding with an SCL edge
    // is a bit edge, never START/STOP.
    assign scl_rise  = scl_s2_reg & ~scl_hist_reg;
    assign scl_fall  = ~scl_s2_reg & scl_hist_reg;
    assign sda_rise  = sda_s2_reg & ~sda_hist_reg;
    assign sda_fall  = ~sda_s2_reg & sda_hist_reg;
    assign scl_high  = scl_s2_reg & scl_hist_reg;
    assign start_det = sda_fall & scl_high;
    assign stop_det  = sda_rise & scl_high;
    assign rx_byte   = {shreg_reg, sda_s2_reg};
    assign rd_byte   = regs[pointer_reg];

    assign sda_oe   = sda_oe_reg;
    assign busy     = busy_reg;
    assign wr_stb   = wr_stb_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign dbg_data = regs[dbg_addr];

    // Two-flop synchronizers plus one history flop per bus line.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            scl_s1_reg <= 1'b1; scl_s2_reg <= 1'b1; scl_hist_reg <= 1'b1;
            sda_s1_reg <= 1'b1; sda_s2_reg <= 1'b1; sda_hist_reg <= 1'b1;
        end else begin
            scl_s1_reg <= scl_i; scl_s2_reg <= scl_s1_reg; scl_hist_reg <= scl_s2_reg;
            sda_s1_reg <= sda_i; sda_s2_reg <= sda_s1_reg; sda_hist_reg <= sda_s2_reg;
        end
    end

    // Protocol state register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shreg_reg      <= 7'd0;
            rw_reg         <= 1'b0;
            first_byte_reg <= 1'b0;
            ack_phase_reg  <= 1'b0;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            pointer_reg    <= '0;
            wr_stb_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= 8'h00;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shreg_reg      <= shreg_next;
            rw_reg         <= rw_next;
            first_byte_reg <= first_byte_next;
            ack_phase_reg  <= ack_phase_next;
            sda_oe_reg     <= sda_oe_next;
            busy_reg       <= busy_next;
            pointer_reg    <= pointer_next;
            wr_stb_reg     <= wr_stb_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    // Next-state logic: START/STOP first, then per-state bit handling.
    // ack_phase marks "ACK slot being driven / master ACK seen".
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shreg_next      = shreg_reg;
        rw_next         = rw_reg;
        first_byte_next = first_byte_reg;
        ack_phase_next  = ack_phase_reg;
        sda_oe_next     = sda_oe_reg;
        busy_next       = busy_reg;
        pointer_next    = pointer_reg;
        wr_stb_next     = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;

        if (start_det) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            ack_phase_next = 1'b0;
        end else if (stop_det) begin
            state_next     = IDLE;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            ack_phase_next = 1'b0;
        end else begin
            case (state_reg)
                ADDR: if (scl_rise) begin
                    shreg_next   = rx_byte[6:0];
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (shreg_reg == TARGET_ADDR) begin
                            state_next     = ADDR_ACK;
                            rw_next        = rx_byte[0];
                            busy_next      = 1'b1;
                            ack_phase_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_next    = 1'b1;
                        ack_phase_next = 1'b1;
                    end else begin
                        ack_phase_next = 1'b0;
                        bit_cnt_next   = 3'd0;
                        if (rw_reg) begin
                            shreg_next  = rd_byte[6:0];
                            sda_oe_next = ~rd_byte[7];
                            state_next  = RD_BYTE;
                        end else begin
                            sda_oe_next     = 1'b0;
                            first_byte_next = 1'b1;
                            state_next      = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shreg_next   = rx_byte[6:0];
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (first_byte_reg) begin
                            pointer_next = rx_byte[AW-1:0];
                        end else begin
                            wr_stb_next  = 1'b1;
                            wr_addr_next = pointer_reg;
                            wr_data_next = rx_byte;
                            pointer_next = pointer_reg + AW'(1);
                        end
                        state_next     = WR_ACK;
                        ack_phase_next = 1'b0;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_next    = 1'b1;
                        ack_phase_next = 1'b1;
                    end else begin
                        sda_oe_next     = 1'b0;
                        ack_phase_next  = 1'b0;
                        first_byte_next = 1'b0;
                        state_next      = WR_BYTE;
                    end
                end
                RD_BYTE: if (scl_fall) begin
                    if (bit_cnt_reg == 3'd7) begin
                        sda_oe_next    = 1'b0;
                        bit_cnt_next   = 3'd0;
                        ack_phase_next = 1'b0;
                        state_next     = RD_ACK;
                    end else begin
                        sda_oe_next  = ~shreg_reg[6];
                        shreg_next   = {shreg_reg[5:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        pointer_next = pointer_reg + AW'(1);
                        if (sda_s2_reg) state_next = RD_WAIT;
                        else            ack_phase_next = 1'b1;
                    end else if (scl_fall && ack_phase_reg) begin
                        // Pointer already advanced on the ACK rise.
                        shreg_next     = rd_byte[6:0];
                        sda_oe_next    = ~rd_byte[7];
                        bit_cnt_next   = 3'd0;
                        ack_phase_next = 1'b0;
                        state_next     = RD_BYTE;
                    end
                end
                RD_WAIT: sda_oe_next = 1'b0;
                default: ;
            endcase
        end
    end

    // Register bank, updated from the registered write strobe.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RST;
        end else if (wr_stb_reg) begin
            regs[wr_addr_reg] <= wr_data_reg;
        end
    end

endmodule
